// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding and the
// opcode field carried in the low nibble of every program word.
package seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

    // Opcode occupies instruction bits [3:0].
    localparam int         OP_LSB   = 0;
    localparam int         OP_W     = 4;
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-flop synchroniser on the raw active-low input, then a
// stability down-counter; emits a one-cycle pulse when the debounced level rises.
module debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_d;

    // The level only flips after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b00;
            cnt     <= RELOAD;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], ~btn_n};
            level_d <= level;
            if (sync[1] == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync[1];
                cnt   <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/instr_sequencer.sv
// Steps through a ROM program image and hands words to a coprocessor with an
// exec/done handshake and timeout. Auto-run is built in when SEQ_AUTORUN_EN is defined.
//
// state | meaning
// IDLE  | waiting for a button event (or auto-run request)
// LOAD  | instr follows the word at idx; registered on exit
// ISSUE | exec strobe, arm the done timeout
// WAIT  | busy, waiting for done or timeout
// GAP   | auto-run spacing before the next word
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int                       INSTR_W     = 22,
    parameter int                       DEPTH       = 21,
    parameter logic [DEPTH*INSTR_W-1:0] PROGRAM     = '0,
    parameter int                       DEB_CYCLES  = 50000,
    parameter int                       TIMEOUT_CYC = 1024,
    parameter int                       GAP_CYC     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_step_n,
    input  logic                       btn_exec_n,
    input  logic                       mode_auto,
    input  logic                       done,
    output logic [INSTR_W-1:0]         instr,
    output logic                       exec,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic                       busy,
    output logic                       err,
    output logic                       prog_end
);
    localparam int IW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IW-1:0] LAST     = IW'(DEPTH - 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

    state_t             st;
    logic [INSTR_W-1:0] instr_q;
    logic [TW-1:0]      tmr;
    logic               booted;
    logic               step_ev;
    logic               exec_ev;
    logic [IW-1:0]      idx_nxt;

    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_step_n), .press(step_ev)
    );
    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_exec (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_exec_n), .press(exec_ev)
    );

    function automatic logic [INSTR_W-1:0] word_at(input logic [IW-1:0] i);
        return PROGRAM[int'(i)*INSTR_W +: INSTR_W];
    endfunction

    assign idx_nxt = (idx == LAST) ? '0 : idx + 1'b1;

`ifdef SEQ_AUTORUN_EN
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
    logic [GW-1:0] gap;
    logic          running;
    logic          prog_end_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            idx     <= '0;
            instr_q <= '0;
            tmr     <= '0;
            err     <= 1'b0;
            booted  <= 1'b0;
`ifdef SEQ_AUTORUN_EN
            gap        <= '0;
            running    <= 1'b0;
            prog_end_q <= 1'b0;
`endif
        end else begin
`ifdef SEQ_AUTORUN_EN
            if (!mode_auto) prog_end_q <= 1'b0;
`endif
            case (st)
                ST_IDLE: begin
                    if (!booted) begin
                        st <= ST_LOAD;
`ifdef SEQ_AUTORUN_EN
                    end else if (mode_auto && !prog_end_q) begin
                        running <= 1'b1;
                        st      <= ST_ISSUE;
`endif
                    end else if (exec_ev) begin
                        st <= ST_ISSUE;
                    end else if (step_ev) begin
                        idx <= idx_nxt;
                        st  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    instr_q <= word_at(idx);
                    booted  <= 1'b1;
`ifdef SEQ_AUTORUN_EN
                    if (running && mode_auto) begin
                        st <= ST_ISSUE;
                    end else begin
                        running <= 1'b0;
                        st      <= ST_IDLE;
                    end
`else
                    st <= ST_IDLE;
`endif
                end
                ST_ISSUE: begin
                    tmr <= TMR_LOAD;
                    st  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
`ifdef SEQ_AUTORUN_EN
                        if (running && idx == LAST) begin
                            prog_end_q <= 1'b1;
                            running    <= 1'b0;
                            st         <= ST_IDLE;
                        end else if (running && mode_auto) begin
                            gap <= GAP_LOAD;
                            st  <= ST_GAP;
                        end else begin
                            running <= 1'b0;
                            st      <= ST_IDLE;
                        end
`else
                        st <= ST_IDLE;
`endif
                    end else if (tmr == '0) begin
                        err <= 1'b1;
`ifdef SEQ_AUTORUN_EN
                        running <= 1'b0;
`endif
                        st <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
`ifdef SEQ_AUTORUN_EN
                ST_GAP: begin
                    if (gap == '0) begin
                        idx <= idx + 1'b1;
                        st  <= ST_LOAD;
                    end else begin
                        gap <= gap - 1'b1;
                    end
                end
`endif
                default: st <= ST_IDLE;
            endcase
        end
    end

    // New word is visible during LOAD itself, so it lands one cycle after the event.
    assign instr = (st == ST_LOAD) ? word_at(idx) : instr_q;
    assign exec  = (st == ST_ISSUE);
    assign busy  = (st == ST_WAIT);

`ifdef SEQ_AUTORUN_EN
    assign prog_end = prog_end_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode_auto, GAP_CYC[0], ST_GAP};
    assign prog_end   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized bench for instr_sequencer; the auto-run section is
// compiled in when SEQ_AUTORUN_EN is defined.
module tb_instr_sequencer;
    localparam int W    = 22;
    localparam int D    = 4;
    localparam int DEB  = 3;
    localparam int TO   = 32;
    localparam int TO2  = 8;
    localparam int GAP  = 4;
    localparam logic [D*W-1:0] PROG = {22'h5, 22'h4, 22'h3, 22'h2};

    logic clk, rst_n;
    logic btn_step_n, btn_exec_n, mode_auto, done;
    logic [W-1:0] instr;
    logic exec, busy, err, prog_end;
    logic [1:0] idx;

    logic btn_step2_n, btn_exec2_n, mode_auto2, done2;
    logic [W-1:0] instr2;
    logic exec2, busy2, err2, prog_end2;
    logic [1:0] idx2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_idx;
    int prog[D] = '{32'h2, 32'h3, 32'h4, 32'h5};

    instr_sequencer #(.INSTR_W(W), .DEPTH(D), .PROGRAM(PROG), .DEB_CYCLES(DEB),
                      .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .btn_step_n(btn_step_n), .btn_exec_n(btn_exec_n),
        .mode_auto(mode_auto), .done(done), .instr(instr), .exec(exec), .idx(idx),
        .busy(busy), .err(err), .prog_end(prog_end));

    instr_sequencer #(.INSTR_W(W), .DEPTH(D), .PROGRAM(PROG), .DEB_CYCLES(DEB),
                      .TIMEOUT_CYC(TO2), .GAP_CYC(GAP)) dut_to (
        .clk(clk), .rst_n(rst_n), .btn_step_n(btn_step2_n), .btn_exec_n(btn_exec2_n),
        .mode_auto(mode_auto2), .done(done2), .instr(instr2), .exec(exec2), .idx(idx2),
        .busy(busy2), .err(err2), .prog_end(prog_end2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_instr", instr, 0);
        check("rst_idx", idx, 0);
        check("rst_busy", busy, 0);
        check("rst_exec", exec, 0);
        check("rst_err", err, 0);
        check("rst_prog_end", prog_end, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        m_idx = 0;
        check("boot_instr", instr, prog[m_idx]);
        check("boot_idx", idx, m_idx);
    endtask

    task automatic do_step();
        bit ok;
        logic [1:0] prev;
        m_idx = (m_idx + 1) % D;
        prev = idx;
        ok = 1'b0;
        btn_step_n = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (idx !== prev) begin ok = 1'b1; break; end
        end
        check("step_seen", ok, 1);
        if (ok) begin
            check("step_idx", idx, m_idx);
            check("step_instr", instr, prog[m_idx]);
        end
        btn_step_n = 1'b1;
        repeat (DEB + 8) @(negedge clk);
        check("step_hold", instr, prog[m_idx]);
    endtask

    // step_mode: 0 none, 1 step pressed in the same cycle, 2 step pressed while busy
    task automatic do_exec(input int dly, input int step_mode);
        bit ok;
        int ex_cnt;
        ok = 1'b0;
        btn_exec_n = 1'b0;
        if (step_mode == 1) btn_step_n = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (exec === 1'b1) begin ok = 1'b1; break; end
        end
        check("exec_seen", ok, 1);
        if (ok) begin
            check("exec_idx", idx, m_idx);
            for (int k = 1; k <= dly; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    btn_exec_n = 1'b1;
                    btn_step_n = (step_mode == 2) ? 1'b0 : 1'b1;
                    check("exec_one_cycle", exec, 0);
                end
                if (k == 12) btn_step_n = 1'b1;
                check("busy_wait", busy, 1);
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check("busy_after_done", busy, 0);
            check("err_after_done", err, 0);
        end
        btn_exec_n = 1'b1;
        btn_step_n = 1'b1;
        ex_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (exec === 1'b1) ex_cnt++;
        end
        check("no_queued_exec", ex_cnt, 0);
        check("idx_hold", idx, m_idx);
        check("instr_hold", instr, prog[m_idx]);
    endtask

    initial begin
        int n_exec;
        int prev_e;
        bit ok;
        rst_n = 1'b1;
        btn_step_n = 1'b1; btn_exec_n = 1'b1; mode_auto = 1'b0; done = 1'b0;
        btn_step2_n = 1'b1; btn_exec2_n = 1'b1; mode_auto2 = 1'b0; done2 = 1'b0;
        m_idx = 0;
        #3 rst_n = 1'b0;
        do_reset();

        // Four steps wrap 1,2,3,0
        repeat (4) do_step();

        do_exec(10, 0);
        do_exec(30, 2);
        do_exec(5, 1);

        // Timeout on the short-timeout instance
        ok = 1'b0;
        btn_exec2_n = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (exec2 === 1'b1) begin ok = 1'b1; break; end
        end
        check("to_exec_seen", ok, 1);
        if (ok) begin
            for (int k = 1; k <= TO2; k++) begin
                @(negedge clk);
                check("to_busy", busy2, 1);
                check("to_err_low", err2, 0);
            end
            @(negedge clk);
            check("to_busy_fall", busy2, 0);
            check("to_err_set", err2, 1);
        end
        btn_exec2_n = 1'b1;

        // Random operations against the index model
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0: do_step();
                1: do_exec(int'($urandom_range(1, TO - 2)), 0);
                default: begin
                    btn_step_n = 1'b0;
                    repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
                    btn_step_n = 1'b1;
                    repeat (12) @(negedge clk);
                    check("glitch_idx", idx, m_idx);
                end
            endcase
        end
        check("to_err_sticky", err2, 1);

        do_reset();
        check("to_err_cleared", err2, 0);

`ifdef SEQ_AUTORUN_EN
        mode_auto = 1'b1;
        prev_e = 0;
        for (int w = 0; w < D; w++) begin
            ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (exec === 1'b1) begin ok = 1'b1; break; end
            end
            check("auto_exec_seen", ok, 1);
            check("auto_idx", idx, w);
            check("auto_instr", instr, prog[w]);
            if (w > 0) check("auto_spacing", cyc - prev_e, 3 + GAP + 2);
            prev_e = cyc;
            repeat (3) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
        end
        check("auto_prog_end", prog_end, 1);
        check("auto_end_idx", idx, D - 1);
        check("auto_end_busy", busy, 0);
        n_exec = 0;
        repeat (30) begin
            @(negedge clk);
            if (exec === 1'b1) n_exec++;
        end
        check("auto_stopped", n_exec, 0);
        mode_auto = 1'b0;
        repeat (3) @(negedge clk);
        m_idx = D - 1;
`else
        mode_auto = 1'b1;
        n_exec = 0;
        repeat (30) begin
            @(negedge clk);
            if (exec === 1'b1) n_exec++;
        end
        check("manual_auto_ignored", n_exec, 0);
        check("manual_prog_end", prog_end, 0);
        check("manual_auto_idx", idx, m_idx);
        mode_auto = 1'b0;
`endif

        // Reset in the middle of WAIT
        while (m_idx == 0) do_step();
        ok = 1'b0;
        btn_exec_n = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (exec === 1'b1) begin ok = 1'b1; break; end
        end
        check("midwait_exec_seen", ok, 1);
        repeat (3) @(negedge clk);
        check("midwait_busy", busy, 1);
        btn_exec_n = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midwait_rst_busy", busy, 0);
        check("midwait_rst_idx", idx, 0);
        check("midwait_rst_instr", instr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midwait_boot_instr", instr, prog[0]);
        check("midwait_boot_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
